uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx / uart_rx.
//   rx_state_t      : receiver FSM states
//   cycles_per_bit  : clock cycles per serial bit (integer division)
//   parity_of       : parity bit a transmitter sends for a data word
//                     (data zero-extended to 9 bits; odd selects odd parity)
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  function automatic int cycles_per_bit(int clk_freq, int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic parity_of(logic [8:0] data, logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs; idles (resets) high.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (second flop)
module uart_rx_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_serial, samples mid-bit, reassembles an
// LSB-first word, checks parity/stop and holds the result in a one-entry
// valid/ready output register.
//   clk, rst_n   : clock, async active-low reset
//   rx_serial    : asynchronous serial line (idle high)
//   rx_data      : received word, stable while rx_valid
//   rx_valid     : output register holds a frame
//   rx_ready     : consumer accepts when rx_valid && rx_ready
//   parity_err   : parity mismatch for the held frame
//   frame_err    : stop bit sampled low for the held frame
//   overrun_err  : one-cycle pulse when a completed frame is dropped
//   busy         : FSM is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CPB  = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic                 rx_s;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 done_q;     // frame finished on the previous edge

  uart_rx_sync #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_serial),
    .q     (rx_s)
  );

  // Receive FSM. Counter free-runs and is cleared on every transition
  // (including the DATA self-loop at each bit boundary).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt    <= cnt + CW'(1);
      done_q <= 1'b0;
      case (state)
        RX_IDLE: if (!rx_s) begin
          state <= RX_START;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        RX_START: if (cnt == CNT_HALF) begin
          cnt <= '0;
          if (!rx_s) begin
            state     <= RX_DATA;
            idx       <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
          end else begin
            // glitch shorter than half a bit
            state <= RX_IDLE;
            busy  <= 1'b0;
          end
        end
        RX_DATA: if (cnt == CNT_LAST) begin
          cnt        <= '0;
          shreg[idx] <= rx_s;
          if (idx == IDX_LAST) state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          else                 idx   <= idx + IW'(1);
        end
        RX_PARITY: if (cnt == CNT_LAST) begin
          cnt       <= '0;
          par_err_q <= (rx_s != parity_of(9'(shreg), ODD));
          state     <= RX_STOP;
        end
        RX_STOP: if (cnt == CNT_LAST) begin
          cnt       <= '0;
          done_q    <= 1'b1;
          frm_err_q <= !rx_s;
          if (rx_s) begin
            state <= RX_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: if (rx_s) begin
          // line held low (break) must not be read as more frames
          state <= RX_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= RX_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register. A new frame may load in the same cycle the
  // held one is accepted; otherwise it is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_err_q;
          frame_err  <= frm_err_q;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_FREQ=16, BAUD_RATE=1 (16 cycles/bit).
// Two instances: even parity (main) and odd parity (parity-select check).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, busy;

  logic       rx_odd = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, pe_o, fe_o, ovr_o, busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_odd), .rx_data(data_o),
    .rx_valid(valid_o), .rx_ready(1'b1), .parity_err(pe_o),
    .frame_err(fe_o), .overrun_err(ovr_o), .busy(busy_o)
  );

  // Monitors sample on posedge (pre-update values); stimulus is driven on negedge.
  logic [9:0] q[$];        // accepted frames {parity_err, frame_err, data}
  int         ovr_cnt = 0;
  int         vld_cycles = 0;
  int         rise_cyc = -1;
  logic       vld_d = 1'b0;
  logic       busy_seen = 1'b0;
  int         odd_cnt = 0;
  logic [9:0] odd_word = '0;

  always @(posedge clk) begin
    if (rx_valid && rx_ready) q.push_back({parity_err, frame_err, rx_data});
    if (overrun_err) ovr_cnt++;
    if (busy) busy_seen = 1'b1;
    if (rx_valid) vld_cycles++;
    if (rx_valid && !vld_d) rise_cyc = cyc;
    vld_d = rx_valid;
    if (valid_o) begin
      odd_cnt++;
      odd_word = {pe_o, fe_o, data_o};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_serial = v;
    else          rx_odd    = v;
  endtask

  // Start, 8 data LSB first, parity, stop; line is left at the stop value.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic p, input logic s);
    set_line(sel, 1'b0); wait_cyc(16);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]); wait_cyc(16);
    end
    set_line(sel, p); wait_cyc(16);
    set_line(sel, s); wait_cyc(16);
  endtask

  int t_start;
  int lat;

  initial begin
    wait_cyc(3);
    // reset state
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data",  32'(rx_data), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_errs",  32'({parity_err, frame_err, overrun_err}), 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: clean 0xA5, ready high, latency
    rx_ready = 1'b1; q.delete(); vld_cycles = 0;
    t_start = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t1_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("t1_word", 32'(q[0]), {22'd0, 2'b00, 8'hA5});
    chk("t1_vld_pulse", 32'(vld_cycles), 1);
    lat = rise_cyc - t_start;
    chk("t1_latency_ok", 32'(lat >= 170 && lat <= 172), 1);

    // 2: wrong parity (even), then odd-parity instance accepts parity 0
    q.delete();
    send_frame(0, 8'h01, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t2_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("t2_even_perr", 32'(q[0]), {22'd0, 2'b10, 8'h01});
    chk("t2_odd_idle", 32'(odd_cnt), 0);
    send_frame(1, 8'h01, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t2_odd_count", 32'(odd_cnt), 1);
    chk("t2_odd_word", 32'(odd_word), {22'd0, 2'b00, 8'h01});

    // 3: framing error with a held-low line, then recovery
    q.delete();
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    wait_cyc(40);
    chk("t3_one_frame", 32'(q.size()), 1);
    if (q.size() > 0) chk("t3_ferr", 32'(q[0]), {22'd0, 2'b01, 8'h3C});
    chk("t3_busy_low", 32'(busy), 1);
    set_line(0, 1'b1);
    wait_cyc(20);
    chk("t3_idle", 32'(busy), 0);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t3_count2", 32'(q.size()), 2);
    if (q.size() > 1) chk("t3_clean", 32'(q[1]), {22'd0, 2'b00, 8'h55});

    // 4: overrun while holding ready low
    rx_ready = 1'b0; q.delete(); ovr_cnt = 0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    wait_cyc(5);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t4_valid", 32'(rx_valid), 1);
    chk("t4_data", 32'(rx_data), 32'h11);
    chk("t4_ovr", 32'(ovr_cnt), 1);
    rx_ready = 1'b1;
    wait_cyc(3);
    chk("t4_drained", 32'(rx_valid), 0);
    wait_cyc(40);
    chk("t4_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("t4_word", 32'(q[0]), {22'd0, 2'b00, 8'h11});
    chk("t4_no22", 32'(rx_valid), 0);

    // 5: short glitch on idle line
    q.delete(); busy_seen = 1'b0;
    set_line(0, 1'b0); wait_cyc(4);
    set_line(0, 1'b1); wait_cyc(30);
    chk("t5_busy_seen", 32'(busy_seen), 1);
    chk("t5_busy_end", 32'(busy), 0);
    chk("t5_no_frame", 32'(q.size()), 0);
    chk("t5_valid", 32'(rx_valid), 0);

    // 6: reset in the middle of data bit 3, with a frame held
    rx_ready = 1'b0;
    send_frame(0, 8'h55, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t6_held", 32'(rx_valid), 1);
    set_line(0, 1'b0); wait_cyc(16);
    set_line(0, 1'b1); wait_cyc(3 * 16 + 8);
    chk("t6_busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 32'({rx_valid, busy, parity_err, frame_err, overrun_err}), 0);
    chk("t6_async_data", 32'(rx_data), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(10);
    rx_ready = 1'b1; q.delete();
    send_frame(0, 8'h81, 1'b0, 1'b1);
    wait_cyc(20);
    chk("t6_count", 32'(q.size()), 1);
    if (q.size() > 0) chk("t6_word", 32'(q[0]), {22'd0, 2'b00, 8'h81});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
